lightgun_hlatch: RTL and testbench

- Console-side receiver for the light-gun sensor line; the input end of the gun emulator's SENSOR output.
- Synchronizes and filters the sensor pulse, drives the TH pin level seen by the I/O port, and latches the beam position at the first qualified hit of each frame.
- Latched values feed the VDP H-counter read port ($7F) and a sticky hit flag.
- Sits between the gun/port multiplexer and the VDP/IO read logic.

---
 rtl/lightgun_hlatch.sv | 114 +++++++++++
 tb/tb_lightgun_hlatch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lightgun_hlatch.sv
// Light-gun sensor receiver: synchronizes and filters the LIGHT line, drives TH,
// and latches the beam position at the first qualified hit of each frame.
module lightgun_hlatch #(
    parameter int         FILTER_LEN = 2,
    parameter logic [8:0] H_OFFSET   = 9'd0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE_PIX,
    input  logic [8:0] HCNT,
    input  logic [8:0] VCNT,
    input  logic       VDE,
    input  logic       LIGHT,
    input  logic       TH_INPUT_EN,
    input  logic       RD_H,
    output logic       TH_LEVEL,
    output logic [7:0] H_LATCH,
    output logic [8:0] V_LATCH,
    output logic       HIT,
    output logic       HIT_PULSE
);

    typedef enum logic [1:0] {IDLE, ARMED, LATCHED} state_t;

    localparam logic [3:0] FILT = 4'(FILTER_LEN);

    state_t     state, next_state;
    logic       light_m, light_s, vde_d;
    logic [3:0] cnt, cnt_next;
    logic       frame_start, do_latch, hit_clr;
    logic [8:0] half_sum;
    logic [7:0] h_val;

    assign frame_start = CE_PIX & VDE & ~vde_d;
    assign cnt_next    = !light_s ? 4'd0 : (cnt == 4'hF) ? 4'hF : cnt + 4'd1;

    // Halved sum carries the 511 saturation in its top bit.
    assign half_sum = 9'(({1'b0, HCNT} + {1'b0, H_OFFSET}) >> 1);
    assign h_val    = half_sum[8] ? 8'hFF : half_sum[7:0];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            light_m  <= 1'b0;
            light_s  <= 1'b0;
            TH_LEVEL <= 1'b1;
        end else begin
            light_m  <= LIGHT;
            light_s  <= light_m;
            TH_LEVEL <= TH_INPUT_EN ? ~light_s : 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!TH_INPUT_EN) begin
            next_state = IDLE;
        end else if (CE_PIX) begin
            case (state)
                IDLE:    next_state = ARMED;
                ARMED:   if (do_latch) next_state = LATCHED;
                LATCHED: if (frame_start) next_state = ARMED;
                default: next_state = IDLE;
            endcase
        end
    end

    // Frame start outranks a qualifying tick, so a held pulse re-qualifies next tick.
    always_comb begin
        do_latch = 1'b0;
        hit_clr  = 1'b0;
        if (TH_INPUT_EN && CE_PIX) begin
            case (state)
                ARMED:   do_latch = !frame_start && (cnt_next >= FILT);
                LATCHED: hit_clr  = frame_start;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt   <= 4'd0;
            vde_d <= 1'b0;
        end else begin
            if (CE_PIX) vde_d <= VDE;
            if (state == IDLE || !TH_INPUT_EN) cnt <= 4'd0;
            else if (CE_PIX)                    cnt <= cnt_next;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            H_LATCH   <= 8'd0;
            V_LATCH   <= 9'd0;
            HIT       <= 1'b0;
            HIT_PULSE <= 1'b0;
        end else begin
            HIT_PULSE <= do_latch;
            if (do_latch) begin
                H_LATCH <= h_val;
                V_LATCH <= VCNT;
                HIT     <= 1'b1;
            end else if (RD_H || hit_clr) begin
                HIT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lightgun_hlatch.sv
// Bench for lightgun_hlatch: two instances (different filter/offset) driven by
// directed and random pixel streams, checked against a behavioural model.
module tb_lightgun_hlatch;

    logic       CLK, RESET_N, CE_PIX, VDE, LIGHT, TH_INPUT_EN, RD_H;
    logic [8:0] HCNT, VCNT;
    logic       th0, th1, hit0, hit1, hp0, hp1;
    logic [7:0] hl0, hl1;
    logic [8:0] vl0, vl1;

    int checks = 0;
    int failures = 0;
    int pc0 = 0;
    int pc1 = 0;

    lightgun_hlatch #(.FILTER_LEN(2), .H_OFFSET(9'd0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HCNT(HCNT), .VCNT(VCNT),
        .VDE(VDE), .LIGHT(LIGHT), .TH_INPUT_EN(TH_INPUT_EN), .RD_H(RD_H),
        .TH_LEVEL(th0), .H_LATCH(hl0), .V_LATCH(vl0), .HIT(hit0), .HIT_PULSE(hp0)
    );

    lightgun_hlatch #(.FILTER_LEN(3), .H_OFFSET(9'd500)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .CE_PIX(CE_PIX), .HCNT(HCNT), .VCNT(VCNT),
        .VDE(VDE), .LIGHT(LIGHT), .TH_INPUT_EN(TH_INPUT_EN), .RD_H(RD_H),
        .TH_LEVEL(th1), .H_LATCH(hl1), .V_LATCH(vl1), .HIT(hit1), .HIT_PULSE(hp1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: light delay line, run of lit pixel ticks, and a per-frame "caught" flag.
    int fl[2]  = '{2, 3};
    int off[2] = '{0, 500};
    int m_run[2], m_hl[2], m_vl[2];
    bit m_en[2], m_caught[2], m_hit[2], m_pulse[2];
    bit m_th, m_lm, m_ls, m_vde;

    task automatic modelStep();
        bit fs;
        bit latch;
        bit clr;
        int hv;
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_hl[i] = 0; m_vl[i] = 0;
                m_en[i] = 0; m_caught[i] = 0; m_hit[i] = 0; m_pulse[i] = 0;
            end
            m_th = 1; m_lm = 0; m_ls = 0; m_vde = 0;
        end else begin
            fs = CE_PIX && VDE && !m_vde;
            for (int i = 0; i < 2; i++) begin
                latch = 0;
                clr   = 0;
                if (!TH_INPUT_EN) begin
                    m_run[i] = 0;
                    m_en[i]  = 0;
                end else if (!m_en[i]) begin
                    m_run[i] = 0;
                    if (CE_PIX) begin
                        m_en[i] = 1;
                        m_caught[i] = 0;
                    end
                end else if (CE_PIX) begin
                    m_run[i] = m_ls ? ((m_run[i] + 1 > 15) ? 15 : m_run[i] + 1) : 0;
                    if (fs) begin
                        clr = m_caught[i];
                        m_caught[i] = 0;
                    end else if (!m_caught[i] && m_run[i] >= fl[i]) begin
                        latch = 1;
                        m_caught[i] = 1;
                    end
                end
                m_pulse[i] = latch;
                if (latch) begin
                    hv = int'(HCNT) + off[i];
                    if (hv > 511) hv = 511;
                    m_hl[i]  = hv / 2;
                    m_vl[i]  = int'(VCNT);
                    m_hit[i] = 1;
                end else if (RD_H || clr) begin
                    m_hit[i] = 0;
                end
            end
            if (CE_PIX) m_vde = VDE;
            m_th = TH_INPUT_EN ? !m_ls : 1'b1;
            m_ls = m_lm;
            m_lm = LIGHT;
        end
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: step the model on the edge, compare both instances just after.
    initial begin
        forever begin
            @(posedge CLK);
            modelStep();
            #1;
            if (hp0) pc0++;
            if (hp1) pc1++;
            checkOutput("th0", int'(th0), int'(m_th));
            checkOutput("hl0", int'(hl0), m_hl[0]);
            checkOutput("vl0", int'(vl0), m_vl[0]);
            checkOutput("hit0", int'(hit0), int'(m_hit[0]));
            checkOutput("pulse0", int'(hp0), int'(m_pulse[0]));
            checkOutput("th1", int'(th1), int'(m_th));
            checkOutput("hl1", int'(hl1), m_hl[1]);
            checkOutput("vl1", int'(vl1), m_vl[1]);
            checkOutput("hit1", int'(hit1), int'(m_hit[1]));
            checkOutput("pulse1", int'(hp1), int'(m_pulse[1]));
        end
    end

    task automatic waitClk();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One pixel = 4 CLKs with CE_PIX on the last; rd selects which CLKs pulse RD_H.
    task automatic applyStimulus(input logic [8:0] h, input logic [8:0] v,
                                 input logic l, input logic vde, input logic [3:0] rd);
        HCNT  = h;
        VCNT  = v;
        LIGHT = l;
        VDE   = vde;
        for (int k = 0; k < 4; k++) begin
            CE_PIX = (k == 3);
            RD_H   = rd[k];
            waitClk();
        end
        CE_PIX = 1'b0;
        RD_H   = 1'b0;
    endtask

    task automatic newFrame();
        applyStimulus(9'd0, 9'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(9'd1, 9'd0, 1'b0, 1'b0, 4'd0);
        applyStimulus(9'd2, 9'd0, 1'b0, 1'b1, 4'd0);
    endtask

    task automatic checkReset();
        checkOutput("rst_th0", int'(th0), 1);
        checkOutput("rst_hl0", int'(hl0), 0);
        checkOutput("rst_vl0", int'(vl0), 0);
        checkOutput("rst_hit0", int'(hit0), 0);
        checkOutput("rst_pulse0", int'(hp0), 0);
        checkOutput("rst_hl1", int'(hl1), 0);
        checkOutput("rst_hit1", int'(hit1), 0);
    endtask

    initial begin
        int p0;
        logic [8:0] h;
        logic [8:0] v;
        logic l;
        logic vde;
        logic [3:0] rd;

        RESET_N = 1'b0;
        CE_PIX = 1'b0; VDE = 1'b0; LIGHT = 1'b0; TH_INPUT_EN = 1'b0; RD_H = 1'b0;
        HCNT = 9'd0; VCNT = 9'd0;
        repeat (2) @(negedge CLK);
        checkReset();
        RESET_N = 1'b1;
        TH_INPUT_EN = 1'b1;

        applyStimulus(9'd10, 9'd60, 1'b0, 1'b0, 4'd0);
        applyStimulus(9'd11, 9'd60, 1'b0, 1'b1, 4'd0);

        // Basic hit, with TH lag observed on the first lit pixel.
        p0 = pc0;
        HCNT = 9'd100; VCNT = 9'd60; LIGHT = 1'b1; VDE = 1'b1;
        waitClk();
        waitClk();
        checkOutput("th_lag2", int'(th0), 1);
        waitClk();
        checkOutput("th_lag3", int'(th0), 0);
        CE_PIX = 1'b1;
        waitClk();
        CE_PIX = 1'b0;
        for (int i = 101; i < 120; i++) applyStimulus(9'(i), 9'd60, 1'b1, 1'b1, 4'd0);
        checkOutput("basic_hl0", int'(hl0), 'h32);
        checkOutput("basic_vl0", int'(vl0), 60);
        checkOutput("basic_hit0", int'(hit0), 1);
        checkOutput("basic_pulses0", pc0 - p0, 1);
        checkOutput("sat_hl1", int'(hl1), 'hFF);

        // Glitch reject.
        newFrame();
        checkOutput("frame_clr_hit0", int'(hit0), 0);
        applyStimulus(9'd70, 9'd5, 1'b1, 1'b1, 4'd0);
        for (int i = 71; i < 74; i++) applyStimulus(9'(i), 9'd5, 1'b0, 1'b1, 4'd0);
        checkOutput("glitch_hit0", int'(hit0), 0);
        checkOutput("glitch_hl0", int'(hl0), 'h32);

        // Once per frame.
        newFrame();
        p0 = pc0;
        for (int i = 40; i < 50; i++) applyStimulus(9'(i), 9'd7, 1'b1, 1'b1, 4'd0);
        for (int i = 50; i < 55; i++) applyStimulus(9'(i), 9'd7, 1'b0, 1'b1, 4'd0);
        for (int i = 180; i < 190; i++) applyStimulus(9'(i), 9'd7, 1'b1, 1'b1, 4'd0);
        checkOutput("once_hl0", int'(hl0), 'h14);
        checkOutput("once_pulses0", pc0 - p0, 1);
        newFrame();
        for (int i = 180; i < 190; i++) applyStimulus(9'(i), 9'd8, 1'b1, 1'b1, 4'd0);
        checkOutput("next_frame_hl0", int'(hl0), 'h5A);
        checkOutput("next_frame_vl0", int'(vl0), 8);

        // RD_H racing the latch, then one CLK later.
        newFrame();
        applyStimulus(9'd60, 9'd9, 1'b1, 1'b1, 4'd0);
        applyStimulus(9'd61, 9'd9, 1'b1, 1'b1, 4'b1000);
        checkOutput("rd_race_hit0", int'(hit0), 1);
        applyStimulus(9'd62, 9'd9, 1'b1, 1'b1, 4'b0001);
        checkOutput("rd_after_hit0", int'(hit0), 0);
        checkOutput("rd_keep_hl0", int'(hl0), 'h1E);

        // TH input disabled during a pulse.
        newFrame();
        TH_INPUT_EN = 1'b0;
        for (int i = 90; i < 100; i++) applyStimulus(9'(i), 9'd10, 1'b1, 1'b1, 4'd0);
        checkOutput("dis_th0", int'(th0), 1);
        checkOutput("dis_hit0", int'(hit0), 0);
        checkOutput("dis_hit1", int'(hit1), 0);
        checkOutput("dis_hl0", int'(hl0), 'h1E);
        TH_INPUT_EN = 1'b1;

        // Reset in the middle of a held pulse.
        applyStimulus(9'd20, 9'd3, 1'b1, 1'b1, 4'd0);
        applyStimulus(9'd21, 9'd3, 1'b1, 1'b1, 4'd0);
        RESET_N = 1'b0;
        #1;
        checkReset();
        waitClk();
        RESET_N = 1'b1;
        applyStimulus(9'd22, 9'd3, 1'b1, 1'b1, 4'd0);
        applyStimulus(9'd23, 9'd3, 1'b1, 1'b1, 4'd0);
        checkOutput("post_rst_hit0", int'(hit0), 0);
        applyStimulus(9'd24, 9'd3, 1'b1, 1'b1, 4'd0);
        checkOutput("post_rst_latch0", int'(hit0), 1);
        checkOutput("post_rst_hl0", int'(hl0), 'h0C);

        // Random traffic, checked cycle by cycle by the model.
        h = 9'd0; v = 9'd0; l = 1'b0; vde = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 49) == 0) TH_INPUT_EN = ~TH_INPUT_EN;
            if ($urandom_range(0, 3) == 0) l = ~l;
            if ($urandom_range(0, 15) == 0) vde = ~vde;
            if ($urandom_range(0, 29) == 0) begin
                h = 9'($urandom_range(0, 511));
                v = 9'($urandom_range(0, 511));
            end else begin
                h = h + 9'd1;
            end
            rd = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
            applyStimulus(h, v, l, vde, rd);
        end

        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
